// File: rtl/icache_pkg.sv
// Shared types and defaults for the instruction-cache line-fill engine.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP,
    S_DRAIN
  } fill_state_e;

  localparam logic [7:0] QSPI_QUAD_READ    = 8'hEB;
  localparam int         DEF_LINE_LENGTH   = 4;
  localparam int         DEF_PA            = 22;
  localparam int         DEF_ADDR_NIBBLES  = 6;
  localparam int         DEF_DUMMY         = 4;

endpackage

// File: rtl/icache_fill_qspi_phy.sv
// QSPI slot sequencer: two clk per nibble slot, sck low then high, with a slot counter
// that restarts whenever the bus goes inactive.
module qspi_phy #(
  parameter int SLOT_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              active,
  input  logic              out_en,
  input  logic [3:0]        out_nibble,
  input  logic [3:0]        io_i,
  output logic              cs_n,
  output logic              sck,
  output logic [3:0]        io_o,
  output logic              io_oe,
  output logic [SLOT_W-1:0] slot,
  output logic              slot_end,
  output logic              sample,
  output logic [3:0]        rx_nibble
);

  logic phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b0;
      slot  <= '0;
    end else if (!active) begin
      phase <= 1'b0;
      slot  <= '0;
    end else begin
      phase <= ~phase;
      if (phase) slot <= slot + 1'b1;
    end
  end

  // The high half of a slot is its last clk, so input nibbles are captured on the edge ending it.
  assign slot_end  = active & phase;
  assign sample    = slot_end & ~out_en;
  assign cs_n      = ~active;
  assign sck       = active & phase;
  assign io_oe     = active & out_en;
  assign io_o      = io_oe ? out_nibble : 4'h0;
  assign rx_nibble = io_i;

endmodule

// File: rtl/icache_fill.sv
// Instruction-cache line fill: quad-SPI read of one line, then a gap-free burst of nibble
// writes into the cache, low nibble of byte 0 first.
module icache_fill
  import icache_pkg::*;
#(
  parameter int         LINE_LENGTH  = DEF_LINE_LENGTH,
  parameter int         PA           = DEF_PA,
  parameter int         ADDR_NIBBLES = DEF_ADDR_NIBBLES,
  parameter int         DUMMY        = DEF_DUMMY,
  parameter logic [7:0] CMD          = QSPI_QUAD_READ
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          pull,
  input  logic [PA-1:$clog2(LINE_LENGTH)] tag,
  input  logic                          fault,
  output logic [3:0]                    dread,
  output logic                          wstrobe_d,
  output logic                          busy,
  output logic                          spi_cs_n,
  output logic                          spi_sck,
  output logic [3:0]                    spi_io_o,
  output logic                          spi_io_oe,
  input  logic [3:0]                    spi_io_i
);

  localparam int OFF    = $clog2(LINE_LENGTH);
  localparam int NIBS   = 2 * LINE_LENGTH;
  localparam int NIB_W  = $clog2(NIBS);
  localparam int BUF_W  = 8 * LINE_LENGTH;
  localparam int ADDR_W = 4 * ADDR_NIBBLES;
  localparam int SLOTS  = 2 + ADDR_NIBBLES + DUMMY + NIBS;
  localparam int SLOT_W = $clog2(SLOTS + 1);

  localparam logic [SLOT_W-1:0] CMD_LAST   = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] ADDR_BASE  = SLOT_W'(2);
  localparam logic [SLOT_W-1:0] ADDR_LAST  = SLOT_W'(2 + ADDR_NIBBLES - 1);
  localparam logic [SLOT_W-1:0] DATA_BASE  = SLOT_W'(2 + ADDR_NIBBLES + DUMMY);
  localparam logic [SLOT_W-1:0] DUMMY_LAST = SLOT_W'(2 + ADDR_NIBBLES + DUMMY - 1);
  localparam logic [SLOT_W-1:0] DATA_LAST  = SLOT_W'(SLOTS - 1);
  localparam logic [NIB_W-1:0]  DRAIN_LAST = NIB_W'(NIBS - 1);

  fill_state_e         state, next_state;
  logic [PA-1:OFF]     r_tag;
  logic [BUF_W-1:0]    line_buf;
  logic [NIB_W-1:0]    drain_cnt;
  logic                start, active, out_en, slot_end, sample;
  logic [SLOT_W-1:0]   slot, addr_idx;
  logic [NIB_W-1:0]    data_idx;
  logic [3:0]          out_nibble, rx_nibble;
  logic [ADDR_W-1:0]   addr_full, addr_shift;

  assign start     = pull && !fault;
  assign active    = state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
  assign out_en    = state inside {S_CMD, S_ADDR};
  assign busy      = (state != S_IDLE);
  assign wstrobe_d = (state == S_DRAIN);
  assign dread     = wstrobe_d ? line_buf[{drain_cnt, 2'b00} +: 4] : 4'h0;

  assign addr_full  = ADDR_W'({r_tag, {OFF{1'b0}}});
  assign addr_idx   = slot - ADDR_BASE;
  assign addr_shift = addr_full << {addr_idx, 2'b00};
  assign data_idx   = NIB_W'(slot - DATA_BASE);

  always_comb begin
    out_nibble = 4'h0;
    if (state == S_CMD)       out_nibble = slot[0] ? CMD[3:0] : CMD[7:4];
    else if (state == S_ADDR) out_nibble = addr_shift[ADDR_W-1 -: 4];
  end

  qspi_phy #(.SLOT_W(SLOT_W)) u_phy (
    .clk        (clk),
    .reset_n    (reset_n),
    .active     (active),
    .out_en     (out_en),
    .out_nibble (out_nibble),
    .io_i       (spi_io_i),
    .cs_n       (spi_cs_n),
    .sck        (spi_sck),
    .io_o       (spi_io_o),
    .io_oe      (spi_io_oe),
    .slot       (slot),
    .slot_end   (slot_end),
    .sample     (sample),
    .rx_nibble  (rx_nibble)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // A tag change by GAP time means the requester moved on, so the buffered line is dropped.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CMD;
      S_CMD:   if (slot_end && slot == CMD_LAST)   next_state = S_ADDR;
      S_ADDR:  if (slot_end && slot == ADDR_LAST)  next_state = S_DUMMY;
      S_DUMMY: if (slot_end && slot == DUMMY_LAST) next_state = S_DATA;
      S_DATA:  if (slot_end && slot == DATA_LAST)  next_state = S_GAP;
      S_GAP:   next_state = (tag == r_tag) ? S_DRAIN : S_IDLE;
      S_DRAIN: if (drain_cnt == DRAIN_LAST) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Bus nibble k lands at bit 4*(k^1): high nibble of each byte arrives first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag     <= '0;
      line_buf  <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == S_IDLE && start) r_tag <= tag;
      if (state == S_DATA && sample)
        line_buf[{data_idx ^ NIB_W'(1), 2'b00} +: 4] <= rx_nibble;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// Bench for icache_fill: a flash model answers the QSPI bus and every clk of each fill is
// compared against the expected fill timeline and line contents.
module tb_icache_fill;

  localparam int LL          = 4;
  localparam int PA          = 22;
  localparam int AN          = 6;
  localparam int DM          = 4;
  localparam int OFF         = 2;
  localparam int TW          = PA - OFF;
  localparam int NIBS        = 2 * LL;
  localparam int SLOTS       = 2 + AN + DM + NIBS;
  localparam int CS_LAST     = 2 * SLOTS;
  localparam int GAP_CYC     = CS_LAST + 1;
  localparam int DRAIN_FIRST = GAP_CYC + 1;
  localparam int DRAIN_LAST  = GAP_CYC + NIBS;
  localparam int OE_LAST     = 2 * (2 + AN);
  localparam int DATA_SLOT0  = 2 + AN + DM;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            pull;
  logic [PA-1:OFF] tag;
  logic            fault;
  logic [3:0]      dread;
  logic            wstrobe_d;
  logic            busy;
  logic            spi_cs_n;
  logic            spi_sck;
  logic [3:0]      spi_io_o;
  logic            spi_io_oe;
  logic [3:0]      spi_io_i;

  int vector_count = 0;
  int miss_count   = 0;

  logic [7:0]  flash_mem [logic [23:0]];
  logic [3:0]  bus_q [$];
  int          slot_cnt;
  bit          in_txn = 1'b0;
  logic [23:0] flash_addr;
  int          fk;
  logic [7:0]  fb;

  icache_fill dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pull      (pull),
    .tag       (tag),
    .fault     (fault),
    .dread     (dread),
    .wstrobe_d (wstrobe_d),
    .busy      (busy),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_io_o  (spi_io_o),
    .spi_io_oe (spi_io_oe),
    .spi_io_i  (spi_io_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] get_byte(input logic [23:0] a);
    if (!flash_mem.exists(a)) flash_mem[a] = 8'($urandom);
    return flash_mem[a];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
    end
  endtask

  // Flash device: records command/address nibbles and returns line bytes after the dummy slots.
  always @(negedge clk) begin
    if (spi_cs_n) begin
      in_txn = 1'b0;
    end else begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        slot_cnt = 0;
        bus_q.delete();
      end
      if (!spi_sck) begin
        if (slot_cnt >= DATA_SLOT0) begin
          fk = slot_cnt - DATA_SLOT0;
          fb = get_byte(flash_addr + 24'(fk / 2));
          spi_io_i = (fk % 2 == 0) ? fb[7:4] : fb[3:0];
        end
      end else begin
        if (spi_io_oe) bus_q.push_back(spi_io_o);
        slot_cnt++;
        if (slot_cnt == 2 + AN && bus_q.size() >= 8)
          flash_addr = {bus_q[2], bus_q[3], bus_q[4], bus_q[5], bus_q[6], bus_q[7]};
      end
    end
  end

  task automatic check_idle(input string name);
    checkOutput(name, 32'({spi_cs_n, spi_sck, spi_io_oe, busy, wstrobe_d, dread}), 32'(10'b1_0_0_0_0_0000));
  endtask

  // Called at a negedge while idle: request a fill that the next posedge accepts.
  task automatic applyStimulus(input logic [PA-1:OFF] t);
    pull  = 1'b1;
    fault = 1'b0;
    tag   = t;
    @(posedge clk);
  endtask

  // Walks cycles 1..last_cycle after the accepting edge; change_at != 0 swaps the tag then.
  task automatic expect_fill(input logic [PA-1:OFF] t, input int last_cycle, input int change_at,
                             input logic [PA-1:OFF] new_tag);
    logic [23:0] base;
    logic [31:0] bus_exp;
    logic [7:0]  b;
    logic [3:0]  exp_nib;
    logic        ws, cs_exp, sck_exp, oe_exp, busy_exp;
    logic [9:0]  exp_vec;
    bit          aborted;
    int          d;
    base    = 24'({t, 2'b00});
    bus_exp = {8'hEB, base};
    aborted = (change_at != 0);
    for (int n = 1; n <= last_cycle; n++) begin
      @(negedge clk);
      exp_nib  = 4'h0;
      ws       = !aborted && n >= DRAIN_FIRST && n <= DRAIN_LAST;
      if (ws) begin
        d       = n - DRAIN_FIRST;
        b       = get_byte(base + 24'(d / 2));
        exp_nib = (d % 2 == 0) ? b[3:0] : b[7:4];
      end
      cs_exp   = (n > CS_LAST);
      sck_exp  = (n <= CS_LAST) && (n % 2 == 0);
      oe_exp   = (n <= OE_LAST);
      busy_exp = aborted ? (n <= GAP_CYC) : (n <= DRAIN_LAST);
      exp_vec  = {cs_exp, sck_exp, oe_exp, busy_exp, ws, exp_nib};
      checkOutput($sformatf("cycle%0d", n),
                  32'({spi_cs_n, spi_sck, spi_io_oe, busy, wstrobe_d, dread}), 32'(exp_vec));
      if (n == GAP_CYC) begin
        checkOutput("bus_len", 32'(bus_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < bus_q.size(); i++)
          checkOutput($sformatf("bus%0d", i), 32'(bus_q[i]), 32'(bus_exp[31-4*i -: 4]));
      end
      if (n == 1) pull = 1'b0;
      fault = (n >= 2 && n < CS_LAST) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (aborted && n == change_at) begin
        tag  = new_tag;
        pull = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not end, %0d vectors", vector_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [PA-1:OFF] ta, tb2;
    reset_n  = 1'b0;
    pull     = 1'b0;
    fault    = 1'b0;
    tag      = '0;
    spi_io_i = 4'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 32'({spi_cs_n, spi_sck, spi_io_oe, busy, wstrobe_d, dread, spi_io_o}),
                32'(14'b1_0_0_0_0_0000_0000));
    reset_n = 1'b1;

    $display("[TB] idle after reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle%0d", i));
    end

    $display("[TB] directed fill, tag 12345");
    flash_mem[24'h048D14] = 8'h11;
    flash_mem[24'h048D15] = 8'h22;
    flash_mem[24'h048D16] = 8'h33;
    flash_mem[24'h048D17] = 8'h44;
    applyStimulus(TW'(20'h12345));
    expect_fill(TW'(20'h12345), DRAIN_LAST + 1, 0, '0);

    $display("[TB] fault blocks start");
    ta    = TW'($urandom);
    pull  = 1'b1;
    fault = 1'b1;
    tag   = ta;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle($sformatf("fault%0d", i));
    end
    fault = 1'b0;
    @(posedge clk);
    expect_fill(ta, DRAIN_LAST + 1, 0, '0);

    $display("[TB] tag change during data");
    ta  = TW'($urandom);
    tb2 = ta ^ TW'(20'h00F01);
    applyStimulus(ta);
    expect_fill(ta, GAP_CYC + 1, 30, tb2);
    @(posedge clk);
    expect_fill(tb2, DRAIN_LAST + 1, 0, '0);

    $display("[TB] reset during drain");
    ta = TW'($urandom);
    applyStimulus(ta);
    expect_fill(ta, 44, 0, '0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 checkOutput("async_reset", 32'({spi_cs_n, spi_sck, spi_io_oe, busy, wstrobe_d, dread}),
                   32'(10'b1_0_0_0_0_0000));
    @(negedge clk);
    check_idle("in_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("post_reset%0d", i));
    end
    applyStimulus(ta);
    expect_fill(ta, DRAIN_LAST + 1, 0, '0);

    $display("[TB] back-to-back misses");
    ta  = TW'($urandom);
    tb2 = TW'($urandom);
    applyStimulus(ta);
    expect_fill(ta, DRAIN_LAST + 1, 0, '0);
    applyStimulus(tb2);
    expect_fill(tb2, DRAIN_LAST + 1, 0, '0);

    $display("[TB] random fills");
    for (int r = 0; r < 6; r++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        @(negedge clk);
        check_idle($sformatf("gap%0d_%0d", r, g));
      end
      ta = TW'($urandom);
      applyStimulus(ta);
      expect_fill(ta, DRAIN_LAST + 1, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
